// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
// Request arbiter and bus-hold sequencer for an 8237-style DMA controller.
// Resolves channel requests under fixed or rotating priority and runs the
// HRQ/HLDA handshake with the CPU. It drives a one-hot DACK to the winning
// channel and releases the bus according to the granted channel's transfer mode.
// Every output is registered. The datapath supplies xferDone/TC for the granted channel.

module dma_channel_arbiter #(
  parameter int NUM_CH           = 4,
  parameter bit DREQ_ACTIVE_HIGH = 1'b1,
  parameter bit DACK_ACTIVE_HIGH = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_CH-1:0]           DREQ,
  input  logic [NUM_CH-1:0]           MASK,
  input  logic [2*NUM_CH-1:0]         MODE,
  input  logic                        ROTATE,
  input  logic                        HLDA,
  input  logic                        xferDone,
  input  logic                        TC,
  input  logic                        EOP_N,
  output logic                        HRQ,
  output logic [NUM_CH-1:0]           DACK,
  output logic                        grantValid,
  output logic [$clog2(NUM_CH)-1:0]   grantChannel,
  output logic                        serviceDone
);

  localparam int CH_W = $clog2(NUM_CH);
  // Index width with one spare bit, so that pointer + offset can be wrapped without overflow.
  localparam int IX_W = CH_W + 1;

  localparam logic [NUM_CH-1:0] DACK_IDLE = DACK_ACTIVE_HIGH ? '0 : '1;

  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } state_t;

  state_t             state;
  logic [NUM_CH-1:0]  dreqEff;
  logic [NUM_CH-1:0]  req;
  logic               anyReq;
  logic [CH_W-1:0]    priPtr;
  logic [CH_W-1:0]    searchStart;
  logic [CH_W-1:0]    winner;
  logic [1:0]         winnerMode;
  logic [1:0]         grantMode;
  logic [CH_W-1:0]    nextPtr;
  logic               grantExit;

  // Pick the first requesting channel, searching upward from start and wrapping past NUM_CH-1.
  function automatic logic [CH_W-1:0] pickWinner(input logic [NUM_CH-1:0] r,
                                                 input logic [CH_W-1:0]   start);
    logic [CH_W-1:0] w;
    logic            found;
    logic [IX_W-1:0] idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, start} + IX_W'(i);
      if (idx >= IX_W'(NUM_CH)) idx = idx - IX_W'(NUM_CH);
      if (!found && r[idx[CH_W-1:0]]) begin
        found = 1'b1;
        w     = idx[CH_W-1:0];
      end
    end
    return w;
  endfunction

  // Two-bit mode field of channel ch.
  function automatic logic [1:0] modeOf(input logic [2*NUM_CH-1:0] m,
                                        input logic [CH_W-1:0]     ch);
    logic [1:0] f;
    f = MODE_OFF;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_W'(k)) f = m[2*k +: 2];
    end
    return f;
  endfunction

  // DACK pattern that acknowledges channel ch, at the configured output polarity.
  function automatic logic [NUM_CH-1:0] dackFor(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return DACK_ACTIVE_HIGH ? oh : ~oh;
  endfunction

  // Correct the request polarity. A channel is then eligible only when it is
  // unmasked and its mode field is not the "masked" code.
  assign dreqEff = DREQ_ACTIVE_HIGH ? DREQ : ~DREQ;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_req
    assign req[k] = dreqEff[k] & ~MASK[k] & (MODE[2*k +: 2] != MODE_OFF);
  end

  assign anyReq      = |req;
  assign searchStart = ROTATE ? priPtr : '0;
  assign winner      = pickWinner(req, searchStart);
  assign winnerMode  = modeOf(MODE, winner);
  assign nextPtr     = (grantChannel == CH_W'(NUM_CH - 1)) ? '0 : grantChannel + CH_W'(1);

  // End-of-service condition for the granted channel. It uses the mode captured at grant,
  // so mode changes made during service do not disturb the transfer in progress.
  always_comb begin
    grantExit = 1'b0;
    case (grantMode)
      MODE_DEMAND: grantExit = ~dreqEff[grantChannel] | (xferDone & TC) | ~EOP_N;
      MODE_SINGLE: grantExit = xferDone;
      MODE_BLOCK:  grantExit = (xferDone & TC) | ~EOP_N;
      default:     grantExit = 1'b1;
    endcase
  end

  // Capture the winner's mode when the bus is granted. The value is meaningful only during GRANT.
  always_ff @(posedge CLK) begin
    if (state == REQ && anyReq && HLDA) grantMode <= winnerMode;
  end

  // Handshake sequencer: IDLE -> REQ -> GRANT -> RELEASE, with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      HRQ          <= 1'b0;
      DACK         <= DACK_IDLE;
      grantValid   <= 1'b0;
      grantChannel <= '0;
      serviceDone  <= 1'b0;
      priPtr       <= '0;
    end else begin
      serviceDone <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            state        <= REQ;
            HRQ          <= 1'b1;
            grantChannel <= winner;
          end
        end
        REQ: begin
          if (!anyReq) begin
            // The request vanished. If the CPU already handed over the bus, give it back cleanly.
            HRQ   <= 1'b0;
            state <= HLDA ? RELEASE : IDLE;
          end else begin
            // Re-resolve every cycle, so a late higher-priority request still wins.
            grantChannel <= winner;
            if (HLDA) begin
              state      <= GRANT;
              DACK       <= dackFor(winner);
              grantValid <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (!HLDA) begin
            // The CPU took the bus back. Abort without counting the service as complete.
            state      <= IDLE;
            HRQ        <= 1'b0;
            DACK       <= DACK_IDLE;
            grantValid <= 1'b0;
          end else if (grantExit) begin
            state       <= RELEASE;
            HRQ         <= 1'b0;
            DACK        <= DACK_IDLE;
            grantValid  <= 1'b0;
            serviceDone <= 1'b1;
            priPtr      <= nextPtr;
          end
        end
        RELEASE: begin
          if (!HLDA) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          HRQ        <= 1'b0;
          DACK       <= DACK_IDLE;
          grantValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter (NUM_CH=4, active-high polarities).
// A behavioural reference model predicts the outputs after every clock edge.
// Directed scenarios add explicit expectations on top of that prediction.

module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] MASK;
  logic [7:0] MODE;
  logic       ROTATE;
  logic       HLDA;
  logic       xferDone;
  logic       TC;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic       serviceDone;

  dma_channel_arbiter #(.NUM_CH(4), .DREQ_ACTIVE_HIGH(1'b1), .DACK_ACTIVE_HIGH(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .MASK(MASK), .MODE(MODE), .ROTATE(ROTATE),
    .HLDA(HLDA), .xferDone(xferDone), .TC(TC), .EOP_N(EOP_N), .HRQ(HRQ), .DACK(DACK),
    .grantValid(grantValid), .grantChannel(grantChannel), .serviceDone(serviceDone)
  );

  always #5 CLK = ~CLK;

  int    nCompared   = 0;
  int    nMismatched = 0;
  string curTest     = "init";

  task automatic checkVal(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs != exp) begin
      nMismatched++;
      $display("FAIL %s.%s: got %0d expected %0d", curTest, tag, obs, exp);
    end
  endtask

  // Reference model. phase: 0 idle, 1 requesting, 2 bus granted, 3 releasing.
  int mPhase, mPtr, mCh, mMode, mHrq, mGv, mSd, mDack;

  function automatic int firstFrom(int r, int start);
    for (int i = 0; i < 4; i++) begin
      int c = (start + i) % 4;
      if (((r >> c) & 1) != 0) return c;
    end
    return 0;
  endfunction

  task automatic modelEdge();
    int r;
    int m;
    bit leave;
    if (RESET) begin
      mPhase = 0; mPtr = 0; mCh = 0; mMode = 0;
      mHrq = 0; mGv = 0; mSd = 0; mDack = 0;
      return;
    end
    r = 0;
    for (int k = 0; k < 4; k++) begin
      m = int'(MODE[2*k +: 2]);
      if (DREQ[k] && !MASK[k] && m != 3) r = r | (1 << k);
    end
    mSd = 0;
    case (mPhase)
      0: if (r != 0) begin
        mPhase = 1; mHrq = 1; mCh = firstFrom(r, ROTATE ? mPtr : 0);
      end
      1: if (r == 0) begin
        mHrq = 0; mPhase = HLDA ? 3 : 0;
      end else begin
        mCh = firstFrom(r, ROTATE ? mPtr : 0);
        if (HLDA) begin
          mPhase = 2; mGv = 1; mDack = 1 << mCh; mMode = int'(MODE[2*mCh +: 2]);
        end
      end
      2: begin
        case (mMode)
          0: leave = !DREQ[mCh] || (xferDone && TC) || !EOP_N;
          1: leave = xferDone;
          default: leave = (xferDone && TC) || !EOP_N;
        endcase
        if (!HLDA) begin
          mPhase = 0; mHrq = 0; mGv = 0; mDack = 0;
        end else if (leave) begin
          mPhase = 3; mHrq = 0; mGv = 0; mDack = 0; mSd = 1; mPtr = (mCh + 1) % 4;
        end
      end
      default: if (!HLDA) mPhase = 0;
    endcase
  endtask

  // One clock: advance the model on the edge, then compare every output 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    modelEdge();
    #1;
    checkVal("HRQ", int'(HRQ), mHrq);
    checkVal("DACK", int'(DACK), mDack);
    checkVal("grantValid", int'(grantValid), mGv);
    checkVal("grantChannel", int'(grantChannel), mCh);
    checkVal("serviceDone", int'(serviceDone), mSd);
  endtask

  task automatic resetDut();
    RESET = 1'b1; DREQ = '0; MASK = '0; MODE = '0; ROTATE = 1'b0;
    HLDA = 1'b0; xferDone = 1'b0; TC = 1'b0; EOP_N = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  int sdCount;

  initial begin
    // Hold reset with every channel requesting and HLDA already high.
    curTest = "reset";
    RESET = 1'b1; DREQ = 4'hF; MASK = '0; MODE = '0; ROTATE = 1'b0;
    HLDA = 1'b1; xferDone = 1'b0; TC = 1'b0; EOP_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkVal("rstHRQ", int'(HRQ), 0);
      checkVal("rstDACK", int'(DACK), 0);
      checkVal("rstGv", int'(grantValid), 0);
    end
    RESET = 1'b0; DREQ = '0; HLDA = 1'b0;
    tick();
    checkVal("postHRQ", int'(HRQ), 0);
    checkVal("postDACK", int'(DACK), 0);
    checkVal("postGv", int'(grantValid), 0);

    // Fixed priority: the lowest requesting index wins.
    curTest = "fixed";
    resetDut();
    DREQ = 4'b1010;
    tick();
    checkVal("hrqUp", int'(HRQ), 1);
    checkVal("winner", int'(grantChannel), 1);
    HLDA = 1'b1;
    tick();
    checkVal("dack", int'(DACK), 4'b0010);
    checkVal("gch", int'(grantChannel), 1);
    DREQ = '0;
    tick();
    HLDA = 1'b0;
    tick();

    // Rotating priority: all channels are in single mode and keep requesting.
    curTest = "rotate";
    resetDut();
    ROTATE = 1'b1; MODE = 8'b01_01_01_01; DREQ = 4'hF;
    sdCount = 0;
    for (int n = 0; n < 5; n++) begin
      tick(); if (serviceDone) sdCount++;
      HLDA = 1'b1;
      tick(); if (serviceDone) sdCount++;
      checkVal("order", int'(grantChannel), order[n]);
      xferDone = 1'b1;
      tick(); if (serviceDone) sdCount++;
      xferDone = 1'b0; HLDA = 1'b0;
      tick(); if (serviceDone) sdCount++;
    end
    checkVal("sdCount", sdCount, 5);

    // A masked channel never raises HRQ.
    curTest = "mask";
    resetDut();
    MASK = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkVal("hrqMasked", int'(HRQ), 0);
    end
    MASK = '0;
    tick();
    checkVal("hrqUnmasked", int'(HRQ), 1);

    // Block mode: DREQ drop is ignored; only xferDone with TC ends the service.
    curTest = "block";
    resetDut();
    MODE = 8'b00_10_00_00; DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    checkVal("dack", int'(DACK), 4'b0100);
    DREQ = '0;
    for (int i = 0; i < 3; i++) begin
      xferDone = 1'b1;
      tick();
      checkVal("dackHeld", int'(DACK), 4'b0100);
      xferDone = 1'b0;
      tick();
      checkVal("dackHeld", int'(DACK), 4'b0100);
    end
    xferDone = 1'b1; TC = 1'b1;
    tick();
    checkVal("dackOff", int'(DACK), 0);
    checkVal("hrqOff", int'(HRQ), 0);
    checkVal("sd", int'(serviceDone), 1);
    xferDone = 1'b0; TC = 1'b0; HLDA = 1'b0;
    tick();

    // The CPU reclaims the bus mid-grant: abort, and leave the pointer unchanged.
    curTest = "preempt";
    resetDut();
    ROTATE = 1'b1; DREQ = 4'b0001;
    tick();
    HLDA = 1'b1;
    tick();
    checkVal("dack", int'(DACK), 4'b0001);
    HLDA = 1'b0;
    tick();
    checkVal("dackOff", int'(DACK), 0);
    checkVal("noSd", int'(serviceDone), 0);
    checkVal("hrqOff", int'(HRQ), 0);
    DREQ = 4'b0011;
    tick();
    checkVal("ptrKept", int'(grantChannel), 0);
    DREQ = '0;
    tick();

    // EOP_N terminates a block-mode service.
    curTest = "eop";
    resetDut();
    MODE = 8'b00_00_10_00; DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    checkVal("dack", int'(DACK), 4'b0010);
    EOP_N = 1'b0;
    tick();
    checkVal("dackOff", int'(DACK), 0);
    checkVal("hrqOff", int'(HRQ), 0);
    checkVal("sd", int'(serviceDone), 1);
    EOP_N = 1'b1; HLDA = 1'b0; DREQ = '0;
    tick();

    // Random traffic. A CPU stand-in answers HRQ with random delays and occasionally reclaims the bus.
    curTest = "random";
    resetDut();
    MODE = 8'($urandom);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      if ($urandom_range(0, 29) == 0) MASK = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 19) == 0) MODE = 8'($urandom);
      if ($urandom_range(0, 49) == 0) ROTATE = ~ROTATE;
      if (HRQ && !HLDA) HLDA = ($urandom_range(0, 1) == 0);
      else if (!HRQ && HLDA) HLDA = ($urandom_range(0, 1) == 0);
      else if (HRQ && HLDA && $urandom_range(0, 29) == 0) HLDA = 1'b0;
      xferDone = ($urandom_range(0, 2) == 0);
      TC       = ($urandom_range(0, 3) == 0);
      EOP_N    = ($urandom_range(0, 11) != 0);
      RESET    = ($urandom_range(0, 499) == 0);
      tick();
    end
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
